// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, tag/op encodings and the reservation-station entry record
package tomasulo_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W = 3;
  localparam logic [TAG_W-1:0] TAG_NONE = '0;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef struct packed {
    logic              busy;
    logic              op;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qk;
  } rs_entry_t;
endpackage

// File: rtl/rs_entry.sv
// rs_entry: one station slot with issue load, CDB operand capture, ready flag and free
module rs_entry
  import tomasulo_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              free,
  input  rs_entry_t         issue,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output rs_entry_t         ent,
  output logic              ready
);
  rs_entry_t nxt;
  // capture runs on the post-load view so an issue-cycle broadcast is not missed
  always_comb begin
    nxt = load ? issue : ent;
    if (free) nxt.busy = 1'b0;
    if (cdb_valid && nxt.busy && nxt.qj != TAG_NONE && nxt.qj == cdb_tag) begin
      nxt.vj = cdb_data;
      nxt.qj = TAG_NONE;
    end
    if (cdb_valid && nxt.busy && nxt.qk != TAG_NONE && nxt.qk == cdb_tag) begin
      nxt.vk = cdb_data;
      nxt.qk = TAG_NONE;
    end
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) ent <= '0;
    else ent <= nxt;
  end
  assign ready = ent.busy && ent.qj == TAG_NONE && ent.qk == TAG_NONE;
endmodule

// File: rtl/mult_reservation_station.sv
// mult_reservation_station: mul/div reservation station with CDB snooping and aligned result tagging
module mult_reservation_station
  import tomasulo_pkg::*;
#(
  parameter int ENTRIES = 2,
  parameter int TAG_BASE = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] resv_out1,
  output logic [DATA_W-1:0] resv_out2,
  output logic              OP,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [2:0]        busy_count
);
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  rs_entry_t ent [ENTRIES];
  rs_entry_t issue_ent;
  logic [ENTRIES-1:0] busy, rdy, load, free;
  logic [IW-1:0] free_idx, rdy_idx;
  logic any_rdy, accept, disp_v;
  logic [TAG_W-1:0] disp_tag;
  // descending scan so the lowest index wins both encoders
  always_comb begin
    free_idx = '0;
    rdy_idx = '0;
    issue_ready = 1'b0;
    any_rdy = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_idx = IW'(i);
        issue_ready = 1'b1;
      end
      if (rdy[i]) begin
        rdy_idx = IW'(i);
        any_rdy = 1'b1;
      end
    end
  end
  assign accept = issue_valid && issue_ready;
  assign issue_tag = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign issue_ent = '{busy: 1'b1, op: issue_op, vj: issue_vj, qj: issue_qj, vk: issue_vk, qk: issue_qk};
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign busy[i] = ent[i].busy;
    assign load[i] = accept && free_idx == IW'(i);
    assign free[i] = any_rdy && rdy_idx == IW'(i);
    rs_entry u_ent (
      .Clock(Clock), .Reset(Reset), .load(load[i]), .free(free[i]), .issue(issue_ent),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .ent(ent[i]), .ready(rdy[i])
    );
  end
  // disp_v/disp_tag ride alongside the operands; res_* lag them by the unit's one-edge latency
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      resv_out1 <= '0;
      resv_out2 <= '0;
      OP <= OP_MUL;
      disp_v <= 1'b0;
      disp_tag <= TAG_NONE;
      res_valid <= 1'b0;
      res_tag <= TAG_NONE;
      busy_count <= '0;
    end else begin
      if (any_rdy) begin
        resv_out1 <= ent[rdy_idx].vj;
        resv_out2 <= ent[rdy_idx].vk;
        OP <= ent[rdy_idx].op;
      end
      disp_v <= any_rdy;
      disp_tag <= any_rdy ? TAG_W'(TAG_BASE) + TAG_W'(rdy_idx) : TAG_NONE;
      res_valid <= disp_v;
      res_tag <= disp_tag;
      busy_count <= busy_count + 3'(accept) - 3'(any_rdy);
    end
  end
endmodule

// File: tb/tb_mult_reservation_station.sv
// tb_mult_reservation_station: table-driven directed checks plus hand sequences for capture and reset
module tb_mult_reservation_station;
  logic Clock = 0, Reset;
  logic issue_valid, issue_ready, issue_op, cdb_valid, OP, res_valid;
  logic [15:0] issue_vj, issue_vk, cdb_data, resv_out1, resv_out2;
  logic [2:0] issue_qj, issue_qk, issue_tag, cdb_tag, res_tag, busy_count;
  int checks = 0, failures = 0;

  mult_reservation_station #(.ENTRIES(2), .TAG_BASE(5)) dut (
    .Clock(Clock), .Reset(Reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_vk(issue_vk),
    .issue_qk(issue_qk), .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .resv_out1(resv_out1), .resv_out2(resv_out2), .OP(OP),
    .res_valid(res_valid), .res_tag(res_tag), .busy_count(busy_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int iv, op, vj, qj, vk, qk, cv, ct, cd;
    int er, et, ec, o1, o2, eop, rv, rt;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int iv, op, vj, qj, vk, qk, cv, ct, cd);
    issue_valid = 1'(iv);
    issue_op = 1'(op);
    issue_vj = 16'(vj);
    issue_qj = 3'(qj);
    issue_vk = 16'(vk);
    issue_qk = 3'(qk);
    cdb_valid = 1'(cv);
    cdb_tag = 3'(ct);
    cdb_data = 16'(cd);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_out(input string n, input int c, o1, o2, op, rv, rt);
    chk({n, " busy_count"}, int'(busy_count), c);
    chk({n, " resv_out1"}, int'(resv_out1), o1);
    chk({n, " resv_out2"}, int'(resv_out2), o2);
    chk({n, " OP"}, int'(OP), op);
    chk({n, " res_valid"}, int'(res_valid), rv);
    chk({n, " res_tag"}, int'(res_tag), rt);
  endtask

  initial begin
    //          iv op vj  qj vk  qk cv ct cd   er et ec o1  o2 op rv rt
    vecs[0]  = '{1, 0, 6,  0, 7,  0, 0, 0, 0,   1, 5, 1, 0,  0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 6, 0, 6,  7, 0, 0, 0};
    vecs[2]  = '{1, 1, 99, 3, 4,  0, 0, 0, 0,   1, 5, 1, 6,  7, 0, 1, 5};
    vecs[3]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 6, 1, 6,  7, 0, 0, 0};
    vecs[4]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 6, 1, 6,  7, 0, 0, 0};
    vecs[5]  = '{0, 0, 0,  0, 0,  0, 1, 3, 20,  1, 6, 1, 6,  7, 0, 0, 0};
    vecs[6]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 6, 0, 20, 4, 1, 0, 0};
    vecs[7]  = '{1, 0, 0,  2, 5,  0, 1, 2, 9,   1, 5, 1, 20, 4, 1, 1, 5};
    vecs[8]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 6, 0, 9,  5, 0, 0, 0};
    vecs[9]  = '{1, 0, 0,  1, 2,  0, 0, 0, 0,   1, 5, 1, 9,  5, 0, 1, 5};
    vecs[10] = '{1, 1, 8,  0, 0,  1, 0, 0, 0,   1, 6, 2, 9,  5, 0, 0, 0};
    vecs[11] = '{1, 0, 1,  0, 1,  0, 0, 0, 0,   0, 0, 2, 9,  5, 0, 0, 0};
    vecs[12] = '{0, 0, 0,  0, 0,  0, 1, 1, 3,   0, 0, 2, 9,  5, 0, 0, 0};
    vecs[13] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   0, 0, 1, 3,  2, 0, 0, 0};
    vecs[14] = '{1, 0, 10, 0, 11, 0, 0, 0, 0,   1, 5, 1, 8,  3, 1, 1, 5};
    vecs[15] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 6, 0, 10, 11,0, 1, 6};
    vecs[16] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 5, 0, 10, 11,0, 1, 5};
    vecs[17] = '{0, 0, 0,  0, 0,  0, 0, 0, 0,   1, 5, 0, 10, 11,0, 0, 0};

    Reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    chk("reset issue_ready", int'(issue_ready), 1);
    chk("reset issue_tag", int'(issue_tag), 5);
    @(posedge Clock);
    #1 Reset = 0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].iv, vecs[i].op, vecs[i].vj, vecs[i].qj, vecs[i].vk, vecs[i].qk,
            vecs[i].cv, vecs[i].ct, vecs[i].cd);
      #1;
      chk($sformatf("v%0d issue_ready", i), int'(issue_ready), vecs[i].er);
      if (vecs[i].er != 0) chk($sformatf("v%0d issue_tag", i), int'(issue_tag), vecs[i].et);
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].ec, vecs[i].o1, vecs[i].o2, vecs[i].eop,
              vecs[i].rv, vecs[i].rt);
    end

    // both operands captured from a single broadcast
    drive(1, 1, 0, 4, 0, 4, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("dual wait", 1, 10, 11, 0, 0, 0);
    tick();
    chk_out("dual hold", 1, 10, 11, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 4, 7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("dual capture", 1, 10, 11, 0, 0, 0);
    tick();
    chk_out("dual dispatch", 0, 7, 7, 1, 0, 0);
    tick();
    chk_out("dual result", 0, 7, 7, 1, 1, 5);
    tick();

    // reset one cycle after a dispatch drops the pending result
    drive(1, 1, 2, 0, 3, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("pre-reset dispatch", 0, 2, 3, 1, 0, 0);
    Reset = 1;
    #1;
    chk_out("mid reset", 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("reset held", 0, 0, 0, 0, 0, 0);
    Reset = 0;
    tick();
    chk_out("after reset", 0, 0, 0, 0, 0, 0);
    chk("after reset issue_ready", int'(issue_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
